// File: rtl/mips_multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller_if
//
// Bundles the controller <-> datapath signals of the multicycle MIPS core.
//
// Signals (direction seen from the controller, i.e. the master modport):
//   Instruction  in   32     IR contents (opcode [31:26], funct [5:0])
//   ZeroFlag     in   1      combinational ALU zero flag
//   PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite    out 1 each
//   RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA  out 1 each
//   ALUSrcB      out  2      00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   PCSrc        out  2      00 ALU result, 01 jump target, 10 ALUout, 11 A
//   ALUoperation out  3      000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   retired      out  CNT_W  count of completed instructions
//   illegal      out  1      sticky illegal-opcode flag
//
// master : the controller.  slave : the datapath (or a bench driving it).
// ---------------------------------------------------------------------------
interface mips_multicycle_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      Instruction;
    logic             ZeroFlag;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemWrite;
    logic             MemRead;
    logic             IRWrite;
    logic             RegDst;
    logic             WriteRegSel;
    logic             MemtoReg;
    logic             WriteDataSel;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSrc;
    logic [2:0]       ALUoperation;

    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport master (
        input  Instruction, ZeroFlag,
        output PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
               RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, ALUoperation, retired, illegal
    );

    modport slave (
        output Instruction, ZeroFlag,
        input  PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
               RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
               ALUSrcB, PCSrc, ALUoperation, retired, illegal
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller
//
// Moore main FSM plus ALU-control decoder for the multicycle MIPS core.
// Every datapath strobe/select is decoded from the current state (RT_EXEC
// additionally looks at funct for the ALU operation). A retired-instruction
// counter advances on the last cycle of each instruction.
//
// Ports:
//   clk  in  system clock, all state changes on the rising edge
//   rst  in  synchronous active-low reset; while low all controls are 0
//   bus  master modport of mips_multicycle_controller_if (IR, zero flag,
//        all control outputs, retired counter, illegal flag)
//
// Parameter:
//   CNT_W  width of the retired counter (wraps modulo 2^CNT_W)
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcode -> HALT, sticky illegal = 1, not retired
//   undefined : unknown opcode behaves as a 3-cycle NOP, illegal tied 0
// ---------------------------------------------------------------------------
module mips_multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_controller_if.master  bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
        RT_EXEC, RT_WB, I_EXEC_ADD, I_EXEC_SLT, I_WB,
        BEQ, JUMP, JAL, JR, HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire_en;

    logic [5:0] opcode;
    logic [5:0] funct;
    assign opcode = bus.Instruction[31:26];
    assign funct  = bus.Instruction[5:0];

    // Register fields and the zero flag are consumed by the datapath only.
    logic unused_inputs;
    assign unused_inputs = ^{bus.Instruction[25:6], bus.ZeroFlag};

    // Unknown R-type functs fall back to ADD and are still written back.
    function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
        case (f)
            6'b100000: return ALU_ADD;
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_set;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            retired_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (retire_en) begin
                retired_q <= retired_q + 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
`endif
        end
    end

    // Next-state logic; retire_en marks the final cycle of an instruction.
    always_comb begin
        state_d   = state_q;
        retire_en = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_set = 1'b0;
`endif
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? JR : RT_EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = I_EXEC_ADD;
                    OP_SLTI:      state_d = I_EXEC_SLT;
                    OP_J:         state_d = JUMP;
                    OP_JAL:       state_d = JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d     = HALT;
                        illegal_set = 1'b1;
`else
                        state_d   = FETCH;
                        retire_en = 1'b1;
`endif
                    end
                endcase
            end
            MEM_ADR:    state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:     state_d = MEM_WB;
            RT_EXEC:    state_d = RT_WB;
            I_EXEC_ADD: state_d = I_WB;
            I_EXEC_SLT: state_d = I_WB;
            MEM_WB, MEM_WR, RT_WB, I_WB, BEQ, JUMP, JAL, JR: begin
                state_d   = FETCH;
                retire_en = 1'b1;
            end
            HALT:       state_d = HALT;
            default:    state_d = FETCH;
        endcase
    end

    // Moore output decode; reset low overrides everything to 0.
    always_comb begin
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegDst       = 1'b0;
        bus.WriteRegSel  = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.WriteDataSel = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'b00;
        bus.PCSrc        = 2'b00;
        bus.ALUoperation = 3'b000;
        case (state_q)
            FETCH: begin
                bus.MemRead      = 1'b1;
                bus.IRWrite      = 1'b1;
                bus.ALUSrcB      = 2'b01;
                bus.ALUoperation = ALU_ADD;
                bus.PCWrite      = 1'b1;
            end
            DECODE: begin
                // Branch target PC + (imm << 2) lands in ALUout.
                bus.ALUSrcB      = 2'b11;
                bus.ALUoperation = ALU_ADD;
            end
            MEM_ADR, I_EXEC_ADD: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = 2'b10;
                bus.ALUoperation = ALU_ADD;
            end
            I_EXEC_SLT: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = 2'b10;
                bus.ALUoperation = ALU_SLT;
            end
            MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            RT_EXEC: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUoperation = alu_from_funct(funct);
            end
            RT_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            I_WB: begin
                bus.RegWrite = 1'b1;
            end
            BEQ: begin
                // The datapath gates the PC load with ZeroFlag.
                bus.ALUSrcA      = 1'b1;
                bus.ALUoperation = ALU_SUB;
                bus.PCWriteCond  = 1'b1;
                bus.PCSrc        = 2'b10;
            end
            JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b01;
            end
            JAL: begin
                // r31 takes the current PC (already PC+4) on the jump edge.
                bus.PCWrite      = 1'b1;
                bus.PCSrc        = 2'b01;
                bus.RegWrite     = 1'b1;
                bus.WriteRegSel  = 1'b1;
                bus.WriteDataSel = 1'b1;
            end
            JR: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b11;
            end
            default: ;
        endcase
        if (!rst) begin
            bus.PCWrite      = 1'b0;
            bus.PCWriteCond  = 1'b0;
            bus.IorD         = 1'b0;
            bus.MemWrite     = 1'b0;
            bus.MemRead      = 1'b0;
            bus.IRWrite      = 1'b0;
            bus.RegDst       = 1'b0;
            bus.WriteRegSel  = 1'b0;
            bus.MemtoReg     = 1'b0;
            bus.WriteDataSel = 1'b0;
            bus.RegWrite     = 1'b0;
            bus.ALUSrcA      = 1'b0;
            bus.ALUSrcB      = 2'b00;
            bus.PCSrc        = 2'b00;
            bus.ALUoperation = 3'b000;
        end
    end

    assign bus.retired = retired_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_controller
//
// Directed bench for mips_multicycle_controller. Control outputs are packed
// into one 19-bit vector (order below) and compared cycle by cycle against
// hand-written expected vectors. A 4-bit counter keeps the wrap test short.
// Honours ILLEGAL_TRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_controller;

    localparam int TB_CNT_W = 4;

    // {PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
    //  RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA,
    //  ALUSrcB[1:0], PCSrc[1:0], ALUoperation[2:0]}
    localparam logic [18:0] E_ZERO   = 19'b0;
    localparam logic [18:0] E_FETCH  = {1'b1, 3'b000, 1'b1, 1'b1, 6'b0, 2'b01, 2'b00, 3'b010};
    localparam logic [18:0] E_DECODE = {12'b0, 2'b11, 2'b00, 3'b010};
    localparam logic [18:0] E_MADR   = {11'b0, 1'b1, 2'b10, 2'b00, 3'b010};
    localparam logic [18:0] E_MRD    = {2'b00, 1'b1, 1'b0, 1'b1, 14'b0};
    localparam logic [18:0] E_MWB    = {8'b0, 1'b1, 1'b0, 1'b1, 8'b0};
    localparam logic [18:0] E_MWR    = {2'b00, 1'b1, 1'b1, 15'b0};
    localparam logic [18:0] E_RTWB   = {6'b0, 1'b1, 3'b000, 1'b1, 8'b0};
    localparam logic [18:0] E_IADD   = {11'b0, 1'b1, 2'b10, 2'b00, 3'b010};
    localparam logic [18:0] E_ISLT   = {11'b0, 1'b1, 2'b10, 2'b00, 3'b111};
    localparam logic [18:0] E_IWB    = {10'b0, 1'b1, 8'b0};
    localparam logic [18:0] E_BEQ    = {1'b0, 1'b1, 9'b0, 1'b1, 2'b00, 2'b10, 3'b110};
    localparam logic [18:0] E_JUMP   = {1'b1, 13'b0, 2'b01, 3'b000};
    localparam logic [18:0] E_JAL    = {1'b1, 6'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 3'b000};
    localparam logic [18:0] E_JR     = {1'b1, 13'b0, 2'b11, 3'b000};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [TB_CNT_W-1:0] exp_ret = '0;
    logic [18:0] ctrl;

    mips_multicycle_controller_if #(.CNT_W(TB_CNT_W)) bus ();

    mips_multicycle_controller #(.CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemWrite,
                   bus.MemRead, bus.IRWrite, bus.RegDst, bus.WriteRegSel,
                   bus.MemtoReg, bus.WriteDataSel, bus.RegWrite, bus.ALUSrcA,
                   bus.ALUSrcB, bus.PCSrc, bus.ALUoperation};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.Instruction = 32'h0;
        bus.ZeroFlag = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (ctrl !== E_ZERO) begin
                errors++; $display("FAIL reset_ctrl%0d got=%b want=%b", i, ctrl, E_ZERO);
            end
        end
        checks++;
        if (bus.retired !== 4'd0) begin
            errors++; $display("FAIL reset_retired got=%0d want=0", bus.retired);
        end
        checks++;
        if (bus.illegal !== 1'b0) begin
            errors++; $display("FAIL reset_illegal got=%b want=0", bus.illegal);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== E_FETCH) begin
            errors++; $display("FAIL reset_first_fetch got=%b want=%b", ctrl, E_FETCH);
        end
        exp_ret = '0;
    endtask

    task automatic test_load_store();
        logic [18:0] lw_seq [5];
        logic [18:0] sw_seq [4];
        lw_seq = '{E_FETCH, E_DECODE, E_MADR, E_MRD, E_MWB};
        sw_seq = '{E_FETCH, E_DECODE, E_MADR, E_MWR};
        bus.Instruction = 32'h8C430004;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctrl !== lw_seq[i] || bus.retired !== exp_ret) begin
                errors++; $display("FAIL lw_cycle%0d ctrl=%b want=%b retired=%0d want=%0d",
                                   i, ctrl, lw_seq[i], bus.retired, exp_ret);
            end
            step();
        end
        exp_ret++;
        checks++;
        if (ctrl !== E_FETCH || bus.retired !== exp_ret) begin
            errors++; $display("FAIL lw_done ctrl=%b want=%b retired=%0d want=%0d",
                               ctrl, E_FETCH, bus.retired, exp_ret);
        end
        bus.Instruction = 32'hAC430004;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctrl !== sw_seq[i] || bus.retired !== exp_ret) begin
                errors++; $display("FAIL sw_cycle%0d ctrl=%b want=%b retired=%0d want=%0d",
                                   i, ctrl, sw_seq[i], bus.retired, exp_ret);
            end
            step();
        end
        exp_ret++;
        checks++;
        if (ctrl !== E_FETCH || bus.retired !== exp_ret) begin
            errors++; $display("FAIL sw_done ctrl=%b want=%b retired=%0d want=%0d",
                               ctrl, E_FETCH, bus.retired, exp_ret);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [6];
        logic [2:0] op  [6];
        logic [18:0] seq [4];
        fn = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        op = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111,    3'b010};
        for (int k = 0; k < 6; k++) begin
            seq = '{E_FETCH, E_DECODE, {11'b0, 1'b1, 2'b00, 2'b00, op[k]}, E_RTWB};
            bus.Instruction = {6'b000000, 5'd4, 5'd5, 5'd2, 5'd0, fn[k]};
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ctrl !== seq[i]) begin
                    errors++; $display("FAIL rtype_f%b_cycle%0d got=%b want=%b", fn[k], i, ctrl, seq[i]);
                end
                step();
            end
            exp_ret++;
            checks++;
            if (ctrl !== E_FETCH || bus.retired !== exp_ret) begin
                errors++; $display("FAIL rtype_f%b_done ctrl=%b retired=%0d want=%0d",
                                   fn[k], ctrl, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_beq();
        logic [18:0] seq [3];
        seq = '{E_FETCH, E_DECODE, E_BEQ};
        for (int z = 1; z >= 0; z--) begin
            bus.Instruction = 32'h10850003;
            bus.ZeroFlag = z[0];
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctrl !== seq[i]) begin
                    errors++; $display("FAIL beq_z%0d_cycle%0d got=%b want=%b", z, i, ctrl, seq[i]);
                end
                step();
            end
            exp_ret++;
            checks++;
            if (ctrl !== E_FETCH || bus.retired !== exp_ret) begin
                errors++; $display("FAIL beq_z%0d_done ctrl=%b retired=%0d want=%0d",
                                   z, ctrl, bus.retired, exp_ret);
            end
        end
        bus.ZeroFlag = 1'b0;
    endtask

    task automatic test_jumps();
        logic [31:0] ins [3];
        logic [18:0] last [3];
        ins  = '{32'h08000010, 32'h0C000010, 32'h00800008};
        last = '{E_JUMP, E_JAL, E_JR};
        for (int k = 0; k < 3; k++) begin
            bus.Instruction = ins[k];
            checks++;
            if (ctrl !== E_FETCH) begin
                errors++; $display("FAIL jump%0d_fetch got=%b want=%b", k, ctrl, E_FETCH);
            end
            step();
            checks++;
            if (ctrl !== E_DECODE) begin
                errors++; $display("FAIL jump%0d_decode got=%b want=%b", k, ctrl, E_DECODE);
            end
            step();
            checks++;
            if (ctrl !== last[k] || bus.retired !== exp_ret) begin
                errors++; $display("FAIL jump%0d_exec ctrl=%b want=%b retired=%0d want=%0d",
                                   k, ctrl, last[k], bus.retired, exp_ret);
            end
            step();
            exp_ret++;
            checks++;
            if (ctrl !== E_FETCH || bus.retired !== exp_ret) begin
                errors++; $display("FAIL jump%0d_done ctrl=%b retired=%0d want=%0d",
                                   k, ctrl, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_itype();
        logic [31:0] ins [2];
        logic [18:0] ex  [2];
        logic [18:0] seq [4];
        ins = '{32'h20850005, 32'h28850005};
        ex  = '{E_IADD, E_ISLT};
        for (int k = 0; k < 2; k++) begin
            seq = '{E_FETCH, E_DECODE, ex[k], E_IWB};
            bus.Instruction = ins[k];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ctrl !== seq[i]) begin
                    errors++; $display("FAIL itype%0d_cycle%0d got=%b want=%b", k, i, ctrl, seq[i]);
                end
                step();
            end
            exp_ret++;
            checks++;
            if (ctrl !== E_FETCH || bus.retired !== exp_ret) begin
                errors++; $display("FAIL itype%0d_done ctrl=%b retired=%0d want=%0d",
                                   k, ctrl, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.Instruction = 32'h8C430004;
        step();
        step();
        checks++;
        if (ctrl !== E_MADR) begin
            errors++; $display("FAIL midrst_before got=%b want=%b", ctrl, E_MADR);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl !== E_ZERO) begin
            errors++; $display("FAIL midrst_comb_zero got=%b want=%b", ctrl, E_ZERO);
        end
        step();
        checks++;
        if (ctrl !== E_ZERO || bus.retired !== 4'd0) begin
            errors++; $display("FAIL midrst_held ctrl=%b retired=%0d want=0", ctrl, bus.retired);
        end
        rst = 1'b1;
        #1;
        exp_ret = '0;
        checks++;
        if (ctrl !== E_FETCH) begin
            errors++; $display("FAIL midrst_refetch got=%b want=%b", ctrl, E_FETCH);
        end
    endtask

    task automatic test_wrap();
        bus.Instruction = 32'h08000010;
        for (int k = 0; k < 20 && exp_ret != 4'd15; k++) begin
            step(); step(); step();
            exp_ret++;
        end
        checks++;
        if (bus.retired !== 4'd15) begin
            errors++; $display("FAIL wrap_max got=%0d want=15", bus.retired);
        end
        step(); step(); step();
        exp_ret++;
        checks++;
        if (bus.retired !== 4'd0 || ctrl !== E_FETCH) begin
            errors++; $display("FAIL wrap_zero retired=%0d want=0 ctrl=%b", bus.retired, ctrl);
        end
    endtask

    task automatic test_illegal();
        bus.Instruction = 32'hFC000000;
        checks++;
        if (ctrl !== E_FETCH) begin
            errors++; $display("FAIL illegal_fetch got=%b want=%b", ctrl, E_FETCH);
        end
        step();
        checks++;
        if (ctrl !== E_DECODE) begin
            errors++; $display("FAIL illegal_decode got=%b want=%b", ctrl, E_DECODE);
        end
        step();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctrl !== E_ZERO || bus.illegal !== 1'b1 || bus.retired !== exp_ret) begin
                errors++; $display("FAIL illegal_halt%0d ctrl=%b illegal=%b retired=%0d want=%0d",
                                   i, ctrl, bus.illegal, bus.retired, exp_ret);
            end
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        exp_ret = '0;
        checks++;
        if (ctrl !== E_FETCH || bus.illegal !== 1'b0 || bus.retired !== 4'd0) begin
            errors++; $display("FAIL illegal_recover ctrl=%b illegal=%b retired=%0d",
                               ctrl, bus.illegal, bus.retired);
        end
`else
        exp_ret++;
        checks++;
        if (ctrl !== E_FETCH || bus.retired !== exp_ret || bus.illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_nop ctrl=%b retired=%0d want=%0d illegal=%b",
                               ctrl, bus.retired, exp_ret, bus.illegal);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_rtype();
        test_beq();
        test_jumps();
        test_itype();
        test_reset_mid();
        test_wrap();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Moore-style main FSM plus ALU-control decoder for the multicycle MIPS core.
- Consumes the instruction register contents and the ALU zero flag from the datapath.
- Produces every datapath control strobe/select each cycle.
- Sits directly upstream of the datapath control inputs. Also keeps a retired-instruction counter for bench and debug use.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- Instruction  in  32  IR contents; opcode [31:26], funct [5:0].
- ZeroFlag  in  1  combinational ALU zero flag.
- PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite  out  1 each  datapath strobes/selects.
- RegDst, WriteRegSel, MemtoReg, WriteDataSel, RegWrite, ALUSrcA  out  1 each  datapath selects/strobes.
- ALUSrcB  out  2  00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- PCSrc  out  2  00 = ALU result, 01 = jump target, 10 = ALUout reg, 11 = A reg.
- ALUoperation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- retired  out  CNT_W  count of completed instructions.
- illegal  out  1  sticky illegal-opcode flag; exists only with the optional feature, otherwise tied 0.

Behaviour:
- Reset:
  - While rst == 0, all control outputs are forced to 0 combinationally.
  - On a rising clk with rst == 0: state <= FETCH, retired <= 0, illegal <= 0.
  - Reset mid-instruction aborts that instruction; no partial writes occur after the reset edge.
- Outputs are decoded from state only. ALUoperation in RT_EXEC also depends on funct. Unlisted signals are 0.
- FETCH:
  - Asserts MemRead, IRWrite, ALUSrcB = 01, ALUoperation = ADD, PCWrite, PCSrc = 00.
  - Next state: DECODE.
- DECODE:
  - Asserts ALUSrcB = 11, ALUoperation = ADD, so the branch target is latched into ALUout.
  - Dispatch on opcode:
    - 100011 lw / 101011 sw -> MEM_ADR
    - 000000 with funct 001000 -> JR
    - other 000000 -> RT_EXEC
    - 000100 beq -> BEQ
    - 001000 addi -> I_EXEC_ADD
    - 001010 slti -> I_EXEC_SLT
    - 000010 j -> JUMP
    - 000011 jal -> JAL
    - anything else -> illegal handling (see Optional Feature).
- MEM_ADR:
  - Asserts ALUSrcA = 1, ALUSrcB = 10, ADD.
  - Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: asserts MemRead, IorD = 1. Next state: MEM_WB.
- MEM_WB: asserts RegWrite, MemtoReg = 1, RegDst = 0. Next state: FETCH; retired increments.
- MEM_WR: asserts MemWrite, IorD = 1. Next state: FETCH; retired increments.
- RT_EXEC:
  - Asserts ALUSrcA = 1, ALUSrcB = 00.
  - ALUoperation from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Any other funct -> ADD; the result is still written back.
  - Next state: RT_WB.
- RT_WB: asserts RegWrite, RegDst = 1, MemtoReg = 0. Next state: FETCH; retired increments.
- I_EXEC_ADD / I_EXEC_SLT:
  - Assert ALUSrcA = 1, ALUSrcB = 10, with ADD / SLT respectively.
  - Next state: I_WB.
- I_WB: asserts RegWrite, RegDst = 0, MemtoReg = 0. Next state: FETCH; retired increments.
- BEQ:
  - Asserts ALUSrcA = 1, ALUSrcB = 00, SUB, PCWriteCond, PCSrc = 10.
  - The PC loads only if ZeroFlag == 1, which the datapath resolves.
  - Next state: FETCH; retired increments.
- JUMP: asserts PCWrite, PCSrc = 01. Next state: FETCH; retired increments.
- JAL:
  - Asserts PCWrite, PCSrc = 01, RegWrite, WriteRegSel = 1, WriteDataSel = 1.
  - Register 31 captures the pre-jump PC (already PC+4) on the same edge.
  - Next state: FETCH; retired increments.
- JR: asserts PCWrite, PCSrc = 11. Next state: FETCH; retired increments.
- CPI:
  - 3 cycles: beq, j, jal, jr.
  - 4 cycles: R-type, addi, slti, sw.
  - 5 cycles: lw.
- The retired counter wraps from 2^CNT_W - 1 to 0 with no flag.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE moves to HALT and sets illegal = 1 (sticky).
  - HALT drives all controls to 0 and is left only by reset.
  - retired does not increment for the illegal instruction.
- Undefined:
  - An unknown opcode returns DECODE -> FETCH as a NOP (3-cycle, counts as retired).
  - illegal is tied 0.

Test Plan:
- Hold rst = 0 for 2 cycles, then release -> all controls 0 during reset; first cycle after release shows MemRead = 1, IRWrite = 1, PCWrite = 1, ALUSrcB = 01, ALUoperation = 010; retired = 0.
- Instruction = 0x8C430004 (lw) -> states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; MEM_WB shows RegWrite = 1, MemtoReg = 1; retired = 1 after 5 cycles.
- Instruction = 0x00851022 (sub) -> RT_EXEC with ALUoperation = 110, ALUSrcA = 1; RT_WB with RegWrite = 1, RegDst = 1; 4 cycles.
- beq (opcode 000100):
  - With ZeroFlag = 1 in the BEQ cycle -> PCWriteCond = 1, PCSrc = 10.
  - With ZeroFlag = 0 -> same outputs; next state is FETCH in both cases.
- Instruction = 0x0C000010 (jal) -> third cycle shows PCWrite = 1, PCSrc = 01, RegWrite = 1, WriteRegSel = 1, WriteDataSel = 1; then FETCH.
- Opcode 111111:
  - With ILLEGAL_TRAP_EN -> illegal = 1, all controls 0 indefinitely until rst = 0.
  - Without it -> FETCH after DECODE, retired increments by 1.
